// File: rtl/pong_pkg.sv
// Shared types and raster constants for the Pong control blocks.
package pong_pkg;

  localparam int HRES     = 1280;
  localparam int VRES     = 720;
  localparam int PADDLE_H = 20;

  // Wide enough for the longest phase (128 frames of game-over overlay).
  localparam int CNT_W = 8;

  typedef logic [3:0] score_t;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Add one point, holding at the winning score so a score never wraps.
  function automatic score_t score_inc(input score_t s, input score_t lim);
    return (s >= lim) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/row_hit_monitor.sv
// Watches one paddle row of the raster and records whether the ball crossed
// it during the current frame, and whether a paddle was under the ball there.
module row_hit_monitor #(
  parameter int HRES = pong_pkg::HRES,
  parameter int ROW  = 0
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic              active_obj,
  input  logic              active_paddle,
  output logic              miss,
  output logic              seen
);

  localparam logic signed [11:0] ROW_S  = 12'(ROW);
  localparam logic signed [11:0] H_LAST = 12'(HRES - 1);

  logic seen_q;
  logic hit_q;
  logic on_row;

  assign on_row = (vpos == ROW_S) && (hpos >= 12'sd0) && (hpos <= H_LAST);

  // Accumulate per-frame flags; fsync clears them after the sequencer has
  // sampled miss/seen on that same edge, so a pixel coinciding with fsync is dropped.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      seen_q <= 1'b0;
      hit_q  <= 1'b0;
    end else if (fsync) begin
      seen_q <= 1'b0;
      hit_q  <= 1'b0;
    end else if (on_row && active_obj) begin
      seen_q <= 1'b1;
      if (active_paddle) begin
        hit_q <= 1'b1;
      end
    end
  end

  assign seen = seen_q;
  assign miss = seen_q & ~hit_q;

endmodule

// File: rtl/match_sequencer.sv
// Round and score controller: serve, play, point pause and match-over phases.
//
//   state | meaning
//   SERVE | ball held at serve position; paddles re-centred in the first frame
//   PLAY  | ball live; a miss at either paddle row scores for the opponent
//   POINT | pause after a point; decides next serve or end of match
//   OVER  | game-over overlay shown; scores cleared when it ends
module match_sequencer #(
  parameter int HRES         = pong_pkg::HRES,
  parameter int VRES         = pong_pkg::VRES,
  parameter int PADDLE_H     = pong_pkg::PADDLE_H,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 128,
  parameter int WIN_SCORE    = 7
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               active_obj,
  input  logic               active_paddle_p1,
  input  logic               active_paddle_p2,
  output logic               obj_rst,
  output logic               paddle_rst,
  output pong_pkg::score_t   score_p1,
  output pong_pkg::score_t   score_p2,
  output logic [1:0]         increment_score,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state_dbg
);

  import pong_pkg::*;

  localparam int ROW_BOT = VRES - PADDLE_H;
  localparam int ROW_TOP = PADDLE_H - 1;

  localparam logic [CNT_W-1:0] SERVE_TC = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_TC = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_TC  = CNT_W'(OVER_FRAMES - 1);
  localparam score_t           WIN      = score_t'(WIN_SCORE);

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;

  logic miss_bot;
  logic seen_bot;
  logic miss_top;
  logic seen_top;
  logic point_bot;
  logic point_top;

  row_hit_monitor #(
    .HRES (HRES),
    .ROW  (ROW_BOT)
  ) u_mon_bot (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .fsync         (fsync),
    .hpos          (hpos),
    .vpos          (vpos),
    .active_obj    (active_obj),
    .active_paddle (active_paddle_p1),
    .miss          (miss_bot),
    .seen          (seen_bot)
  );

  row_hit_monitor #(
    .HRES (HRES),
    .ROW  (ROW_TOP)
  ) u_mon_top (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .fsync         (fsync),
    .hpos          (hpos),
    .vpos          (vpos),
    .active_obj    (active_obj),
    .active_paddle (active_paddle_p2),
    .miss          (miss_top),
    .seen          (seen_top)
  );

  // A miss implies the ball reached the row; qualifying with seen keeps that explicit.
  assign point_bot = seen_bot & miss_bot;
  assign point_top = seen_top & miss_top;

  // Phase sequencing, frame counting and scoring; all transitions happen on fsync.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state           <= SERVE;
      frame_cnt       <= '0;
      score_p1        <= '0;
      score_p2        <= '0;
      increment_score <= 2'b00;
      game_over       <= 1'b0;
      winner          <= 1'b0;
      obj_rst         <= 1'b1;
      paddle_rst      <= 1'b1;
    end else begin
      increment_score <= 2'b00;
      if (fsync) begin
        case (state)
          SERVE: begin
            paddle_rst <= 1'b0;
            if (frame_cnt == SERVE_TC) begin
              state     <= PLAY;
              frame_cnt <= '0;
              obj_rst   <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          PLAY: begin
            if (point_bot || point_top) begin
              state     <= POINT;
              frame_cnt <= '0;
              obj_rst   <= 1'b1;
              // Both rows missing in one frame is treated as a glitch: no score.
              if (point_bot && !point_top) begin
                score_p2        <= score_inc(score_p2, WIN);
                increment_score <= 2'b10;
              end else if (point_top && !point_bot) begin
                score_p1        <= score_inc(score_p1, WIN);
                increment_score <= 2'b01;
              end
            end
          end
          POINT: begin
            if (frame_cnt == POINT_TC) begin
              frame_cnt  <= '0;
              paddle_rst <= 1'b1;
              if (score_p1 == WIN || score_p2 == WIN) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= (score_p2 == WIN);
              end else begin
                state <= SERVE;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          OVER: begin
            if (frame_cnt == OVER_TC) begin
              state     <= SERVE;
              frame_cnt <= '0;
              score_p1  <= '0;
              score_p2  <= '0;
              game_over <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          default: begin
            state     <= SERVE;
            frame_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_match_sequencer.sv
// Randomised bench for match_sequencer: a frame-level reference model predicts
// the outputs after every fsync; a monitor pops and compares them.
module tb_match_sequencer;

  logic               pixel_clk = 1'b0;
  logic               rst;
  logic               fsync;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               active_obj;
  logic               active_paddle_p1;
  logic               active_paddle_p2;
  logic               obj_rst;
  logic               paddle_rst;
  logic [3:0]         score_p1;
  logic [3:0]         score_p2;
  logic [1:0]         increment_score;
  logic               game_over;
  logic               winner;
  logic [1:0]         state_dbg;

  always #5 pixel_clk = ~pixel_clk;

  match_sequencer dut (
    .pixel_clk        (pixel_clk),
    .rst              (rst),
    .fsync            (fsync),
    .hpos             (hpos),
    .vpos             (vpos),
    .active_obj       (active_obj),
    .active_paddle_p1 (active_paddle_p1),
    .active_paddle_p2 (active_paddle_p2),
    .obj_rst          (obj_rst),
    .paddle_rst       (paddle_rst),
    .score_p1         (score_p1),
    .score_p2         (score_p2),
    .increment_score  (increment_score),
    .game_over        (game_over),
    .winner           (winner),
    .state_dbg        (state_dbg)
  );

  typedef struct {
    int st;
    int orst;
    int prst;
    int s1;
    int s2;
    int inc;
    int go;
    int win;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  logic fs_q   = 1'b0;

  // Reference model: phase 0 serve, 1 play, 2 point, 3 over.
  int m_phase, m_frames, m_s1, m_s2, m_win, m_overs;
  bit f_seen_bot, f_hit_bot, f_seen_top, f_hit_top;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_frames = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    f_seen_bot = 0; f_hit_bot = 0; f_seen_top = 0; f_hit_top = 0;
  endtask

  task automatic model_fsync(output exp_t e);
    bit mb, mt;
    int inc;
    mb  = f_seen_bot && !f_hit_bot;
    mt  = f_seen_top && !f_hit_top;
    inc = 0;
    case (m_phase)
      0: begin
        m_frames++;
        if (m_frames == 60) begin m_phase = 1; m_frames = 0; end
      end
      1: begin
        if (mb || mt) begin
          if (mb && !mt) begin m_s2 = (m_s2 < 7) ? m_s2 + 1 : m_s2; inc = 2; end
          else if (mt && !mb) begin m_s1 = (m_s1 < 7) ? m_s1 + 1 : m_s1; inc = 1; end
          m_phase = 2; m_frames = 0;
        end
      end
      2: begin
        m_frames++;
        if (m_frames == 90) begin
          m_frames = 0;
          if (m_s1 == 7 || m_s2 == 7) begin m_phase = 3; m_win = (m_s2 == 7) ? 1 : 0; end
          else m_phase = 0;
        end
      end
      default: begin
        m_frames++;
        if (m_frames == 128) begin
          m_s1 = 0; m_s2 = 0; m_phase = 0; m_frames = 0; m_overs++;
        end
      end
    endcase
    f_seen_bot = 0; f_hit_bot = 0; f_seen_top = 0; f_hit_top = 0;
    e.st   = m_phase;
    e.orst = (m_phase != 1) ? 1 : 0;
    e.prst = ((m_phase == 0 && m_frames == 0) || m_phase == 3) ? 1 : 0;
    e.s1   = m_s1;
    e.s2   = m_s2;
    e.inc  = inc;
    e.go   = (m_phase == 3) ? 1 : 0;
    e.win  = m_win;
  endtask

  // One random raster pixel, biased towards the two paddle rows and their edges.
  task automatic drive_pixel();
    int r, h, v;
    bit obj, p1, p2;
    r = $urandom_range(0, 7);
    h = $urandom_range(0, 1279);
    case (r)
      0: begin v = 700; if ($urandom_range(0, 3) == 0) h = ($urandom_range(0, 1) != 0) ? 0 : 1279; end
      1: v = 700;
      2: begin v = 19; if ($urandom_range(0, 3) == 0) h = ($urandom_range(0, 1) != 0) ? 0 : 1279; end
      3: v = 19;
      4: v = $urandom_range(0, 719);
      5: begin v = 700; h = ($urandom_range(0, 1) != 0) ? -1 - $urandom_range(0, 20) : 1280 + $urandom_range(0, 20); end
      6: begin v = 19;  h = ($urandom_range(0, 1) != 0) ? -1 - $urandom_range(0, 20) : 1280 + $urandom_range(0, 20); end
      default: v = -1 - $urandom_range(0, 30);
    endcase
    obj = ($urandom_range(0, 3) == 0);
    p1  = ($urandom_range(0, 1) != 0);
    p2  = ($urandom_range(0, 1) != 0);
    fsync = 1'b0; hpos = 12'(h); vpos = 12'(v);
    active_obj = obj; active_paddle_p1 = p1; active_paddle_p2 = p2;
    if (obj && h >= 0 && h < 1280) begin
      if (v == 700) begin f_seen_bot = 1; if (p1) f_hit_bot = 1; end
      if (v == 19)  begin f_seen_top = 1; if (p2) f_hit_top = 1; end
    end
  endtask

  task automatic run_frame();
    exp_t e;
    repeat (3) begin
      @(negedge pixel_clk);
      drive_pixel();
    end
    @(negedge pixel_clk);
    fsync = 1'b1; hpos = 12'sd600; vpos = 12'sd700;
    active_obj = 1'b0; active_paddle_p1 = 1'b0; active_paddle_p2 = 1'b0;
    model_fsync(e);
    expq.push_back(e);
  endtask

  // Track which cycles carried an fsync so the monitor knows when a response is due.
  always @(posedge pixel_clk) fs_q <= fsync && !rst;

  // Scoreboard monitor: compare the frame response after each fsync edge,
  // and require increment_score to stay low on every other cycle.
  always @(negedge pixel_clk) begin
    if (mon_en) begin
      if (fs_q) begin
        if (expq.size() == 0) begin
          chk("queue_underflow", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          chk("state_dbg", int'(state_dbg), mon_e.st);
          chk("obj_rst", int'(obj_rst), mon_e.orst);
          chk("paddle_rst", int'(paddle_rst), mon_e.prst);
          chk("score_p1", int'(score_p1), mon_e.s1);
          chk("score_p2", int'(score_p2), mon_e.s2);
          chk("increment_score", int'(increment_score), mon_e.inc);
          chk("game_over", int'(game_over), mon_e.go);
          chk("winner", int'(winner), mon_e.win);
        end
      end else begin
        chk("inc_idle", int'(increment_score), 0);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(state_dbg), 0);
    chk({tag, "_obj_rst"}, int'(obj_rst), 1);
    chk({tag, "_paddle_rst"}, int'(paddle_rst), 1);
    chk({tag, "_score_p1"}, int'(score_p1), 0);
    chk({tag, "_score_p2"}, int'(score_p2), 0);
    chk({tag, "_inc"}, int'(increment_score), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_winner"}, int'(winner), 0);
  endtask

  initial begin
    int frames;
    rst = 1'b1; fsync = 1'b0; hpos = '0; vpos = '0;
    active_obj = 1'b0; active_paddle_p1 = 1'b0; active_paddle_p2 = 1'b0;
    model_reset();
    m_overs = 0;
    repeat (3) @(negedge pixel_clk);
    check_reset_values("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Play a full match through the game-over overlay and back to serve.
    frames = 0;
    while (m_overs < 1 && frames < 8000) begin
      run_frame();
      frames++;
    end
    chk("first_match_completed", m_overs, 1);

    // Second match: reset in the middle of frame 50 of the overlay.
    frames = 0;
    while (!(m_phase == 3 && m_frames == 50) && frames < 8000) begin
      run_frame();
      frames++;
    end
    chk("over_frame50_reached", (m_phase == 3 && m_frames == 50) ? 1 : 0, 1);
    @(negedge pixel_clk);
    drive_pixel();
    @(negedge pixel_clk);
    rst = 1'b1; active_obj = 1'b0;
    @(negedge pixel_clk);
    check_reset_values("mid_over_rst");
    rst = 1'b0;
    model_reset();

    repeat (70) run_frame();
    @(negedge pixel_clk);
    fsync = 1'b0;
    repeat (3) @(negedge pixel_clk);
    chk("queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
Round and score controller for the Pong datapath. It watches the shared raster (hpos/vpos) together with the ball and paddle active flags, and detects a per-frame hit or miss at each paddle row. It sequences serve, play, point pause and match-over phases, and drives the ball/paddle reset lines, per-player score counters, score-increment pulses and the game-over overlay enable. It sits in the top level between hdmi_transmit timing and the object, paddle, scoreboard and gameover overlay instances.

Parameters:
- HRES, 1280, active pixels per line.
- VRES, 720, active lines per frame.
- PADDLE_H, 20, paddle height in lines.
- SERVE_FRAMES, 60, frames the ball is held in reset before each serve.
- POINT_FRAMES, 90, frames of pause after a point.
- OVER_FRAMES, 128, frames the game-over overlay is shown.
- WIN_SCORE, 7, points needed to win the match (1..15).

Ports:
- pixel_clk  in  1  pixel clock.
- rst  in  1  reset.
- fsync  in  1  single-cycle frame-start pulse.
- hpos  in  12 (signed)  current column.
- vpos  in  12 (signed)  current line.
- active_obj  in  1  ball covers the current pixel.
- active_paddle_p1  in  1  bottom paddle covers the current pixel.
- active_paddle_p2  in  1  top paddle covers the current pixel.
- obj_rst  out  1  hold ball at serve position.
- paddle_rst  out  1  re-centre paddles.
- score_p1  out  4  player 1 score.
- score_p2  out  4  player 2 score.
- increment_score  out  2  one-cycle point pulse; bit0 = p1, bit1 = p2.
- game_over  out  1  overlay enable.
- winner  out  1  0 = p1, 1 = p2; valid while game_over.
- state_dbg  out  2  encoded FSM state.

Behaviour:
- Reset is synchronous, active-high (rst), on pixel_clk. On reset:
  - state = SERVE, frame counter = 0.
  - Scores = 0, increment_score = 0, game_over = 0, winner = 0.
  - obj_rst = 1, paddle_rst = 1.
  - All row flags are cleared.
- Row monitors: ROW_BOT = VRES-PADDLE_H and ROW_TOP = PADDLE_H-1. Each monitor runs only while hpos is in 0..HRES-1.
  - On ROW_BOT: active_obj sets seen_bot. active_obj && active_paddle_p1 sets hit_bot.
  - On ROW_TOP: the same rule sets seen_top and hit_top, using active_paddle_p2.
- At each fsync the flags are sampled and then cleared on the same edge:
  - miss_bot = seen_bot && !hit_bot
  - miss_top = seen_top && !hit_top
- FSM transitions take effect on the fsync edge only. Counters count fsync pulses.
- SERVE:
  - obj_rst = 1. paddle_rst = 1 only during the first frame of SERVE.
  - After SERVE_FRAMES fsyncs, go to PLAY with the counter cleared.
- PLAY:
  - obj_rst = 0.
  - miss_bot only: score_p2 += 1, increment_score[1] pulses on the cycle after the fsync edge, then go to POINT.
  - miss_top only: mirror of the above for p1.
  - Both misses in the same frame (glitch case): no score change, go to POINT.
  - Neither: stay in PLAY.
- POINT:
  - obj_rst = 1.
  - After POINT_FRAMES fsyncs:
    - If either score == WIN_SCORE, go to OVER and latch winner.
    - Otherwise go to SERVE.
- OVER:
  - game_over = 1, obj_rst = 1, paddle_rst = 1.
  - After OVER_FRAMES fsyncs: clear both scores, game_over = 0, go to SERVE.
- Score arithmetic: 4-bit, saturating at WIN_SCORE. Scores never wrap.
- increment_score is exactly one pixel_clk wide and occurs at most once per frame.
- Row flags from the frame in which a state transition happens are discarded. No scoring occurs outside PLAY.
- rst asserted mid-frame or mid-state aborts to the reset values on the next edge. Scores are lost.
- fsync arriving while hpos/vpos is on a monitored row: the sample happens first, then the clear; both occur on the same edge.

Decomposition:
- Shared package pong_pkg holds:
  - The state enum: SERVE, PLAY, POINT, OVER.
  - HRES, VRES, PADDLE_H.
  - The score_t typedef (logic [3:0]).
- One sub-module, row_hit_monitor, parameterised by ROW.
  - Inputs: hpos, vpos, active_obj, active_paddle, fsync.
  - Outputs: registered miss/seen.
  - Instantiated twice (top and bottom).
  - The FSM, counters and scoring stay in match_sequencer.

Test Plan:
- Reset, then 60 fsync pulses with no ball -> obj_rst=1 throughout; state reaches PLAY on the 60th fsync; paddle_rst high only during frame 0.
- PLAY, ball on line 700 at hpos 600, p1 paddle covering 500..700 -> no increment_score; state stays PLAY.
- PLAY, ball on line 700 with no p1 paddle overlap -> at next fsync score_p2 goes 0->1, increment_score=2'b10 for one cycle, state POINT; returns to SERVE after 90 frames.
- Ball seen on both line 19 and line 700 with no paddle overlap, same frame -> scores unchanged, state POINT.
- score_p1 = 6, top miss -> score_p1 = 7, POINT for 90 frames, then OVER with winner=0 and game_over=1 for 128 frames, then scores 0 and SERVE.
- rst asserted during OVER at frame 50 -> next cycle game_over=0, scores 0, state SERVE, obj_rst=1.
